// File: rtl/systema_ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The request struct carries one master's command into the RAM-side mux.
package systema_ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;
    localparam int CNT_W_DEF  = 16;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] address;
        logic [BE_W_DEF-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [DATA_W_DEF-1:0] writedata;
    } req_t;

endpackage

// File: rtl/systema_ram_arbiter_if.sv
// Two Avalon-MM slave ports plus the RAM-side port, bundled for the arbiter.
// "slave" is the arbiter's view; "master" is the view of the masters and RAM around it.
interface systema_ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;
    logic              m0_waitrequest;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;
    logic              m1_waitrequest;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_readdata, m0_readdatavalid, m0_waitrequest,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_readdata, m1_readdatavalid, m1_waitrequest,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_readdata, m0_readdatavalid, m0_waitrequest,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_readdata, m1_readdatavalid, m1_waitrequest,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata
    );

endinterface

// File: rtl/systema_ram_rr_arb.sv
// Two-way round-robin grant, purely combinational; zero latency.
// On a conflict the port that did not win last time gets the one-hot grant.
module systema_ram_rr_arb (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (&req_i) begin
                grant_o = last_grant_i ? 2'b01 : 2'b10;
            end else begin
                grant_o = req_i;
            end
        end
    end

endmodule

// File: rtl/systema_ram_arbiter.sv
// Shares a 1-cycle-latency single-port RAM between two Avalon-MM masters, round-robin.
// Grant and write complete in the request cycle; read data returns one clock after accept.
module systema_ram_arbiter
    import systema_ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = BE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_conflicts,
    systema_ram_arbiter_if.slave bus
);

    logic [1:0]       req;
    logic [1:0]       grant;
    logic             arb_en;
    logic             accept;
    logic             sel_port;
    req_t             p0, p1, sel;

    logic             last_grant_q, last_grant_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_port_q, rd_port_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign req    = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
    assign arb_en = ~freeze & ~reset;

    systema_ram_rr_arb u_rr_arb (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .enable_i     (arb_en),
        .grant_o      (grant)
    );

    assign p0 = '{bus.m0_address, bus.m0_byteenable, bus.m0_read, bus.m0_write, bus.m0_writedata};
    assign p1 = '{bus.m1_address, bus.m1_byteenable, bus.m1_read, bus.m1_write, bus.m1_writedata};

    // Grant is already qualified by request and enable, so any grant bit is an accept.
    // When idle the RAM bus keeps showing the last winner's command.
    assign accept   = |grant;
    assign sel_port = accept ? grant[PORT1] : last_grant_q;
    assign sel      = sel_port ? p1 : p0;

    assign bus.ram_address    = sel.address;
    assign bus.ram_byteenable = sel.byteenable;
    assign bus.ram_writedata  = sel.writedata;
    assign bus.ram_chipselect = accept;
    assign bus.ram_write      = accept & sel.write;
    assign bus.ram_clken      = ~freeze;

    assign bus.m0_waitrequest = reset | freeze | (req[PORT0] & ~grant[PORT0]);
    assign bus.m1_waitrequest = reset | freeze | (req[PORT1] & ~grant[PORT1]);

    assign bus.m0_readdata      = bus.ram_readdata;
    assign bus.m1_readdata      = bus.ram_readdata;
    assign bus.m0_readdatavalid = rd_pend_q & ~rd_port_q & ~reset;
    assign bus.m1_readdatavalid = rd_pend_q &  rd_port_q & ~reset;

    assign stat_conflicts = cnt_q;

    always_comb begin
        last_grant_d = last_grant_q;
        rd_pend_d    = 1'b0;
        rd_port_d    = rd_port_q;
        cnt_d        = cnt_q;

        if (accept) begin
            last_grant_d = grant[PORT1];
            rd_port_d    = grant[PORT1];
            // read+write together is treated as a write
            rd_pend_d    = sel.read & ~sel.write;
        end

        if (stat_clear) begin
            cnt_d = '0;
        end else if ((&req) && !freeze && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_port_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_port_q    <= rd_port_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_systema_ram_arbiter.sv
// Bench for systema_ram_arbiter: directed scenarios plus a randomized run against a reference model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_systema_ram_arbiter;
    import systema_ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic        stat_clear;
    logic [15:0] stat_conflicts;
    int          checks = 0;
    int          errors = 0;

    systema_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) bus ();

    systema_ram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .freeze         (freeze),
        .stat_clear     (stat_clear),
        .stat_conflicts (stat_conflicts),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // RAM: registered address, unregistered q, everything gated by clken
    logic [31:0] ram_mem [0:1023];
    logic [9:0]  ram_addr_q;
    always @(posedge clk) begin
        if (bus.ram_clken) begin
            ram_addr_q <= bus.ram_address;
            if (bus.ram_chipselect && bus.ram_write)
                for (int b = 0; b < 4; b++)
                    if (bus.ram_byteenable[b]) ram_mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
        end
    end
    assign bus.ram_readdata = ram_mem[ram_addr_q];

    logic [31:0] exp_mem [0:1023];

    task automatic exp_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic idle();
        bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_read = 0; bus.m0_write = 0; bus.m0_writedata = '0;
        bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_read = 0; bus.m1_write = 0; bus.m1_writedata = '0;
        freeze = 0; stat_clear = 0;
    endtask

    task automatic drive(input int port, input logic rd, input logic wr, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (port == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_writedata = d; bus.m0_byteenable = be;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_writedata = d; bus.m1_byteenable = be;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        drive(1, 0, 1, 10'h006, 32'h1, 4'hF);
        @(negedge clk);
        checks++; if (bus.m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0: got %b expected 1", bus.m0_waitrequest); end
        checks++; if (bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1: got %b expected 1", bus.m1_waitrequest); end
        checks++; if (bus.ram_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", bus.ram_chipselect); end
        checks++; if (bus.ram_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.ram_write); end
        checks++; if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid}); end
        checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL reset_stat: got %h expected 0000", stat_conflicts); end
        next_cycle();
        reset = 0;
        idle();
    endtask

    task automatic test_write_read();
        drive(0, 0, 1, 10'h005, 32'hDEADBEEF, 4'hF);
        exp_write(10'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_wait0: got %b expected 0", bus.m0_waitrequest); end
        checks++; if ({bus.ram_chipselect, bus.ram_write} !== 2'b11) begin errors++; $display("FAIL wr_ram: got %b expected 11", {bus.ram_chipselect, bus.ram_write}); end
        next_cycle();
        idle();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait0: got %b expected 0", bus.m0_waitrequest); end
        checks++; if ({bus.ram_chipselect, bus.ram_write} !== 2'b10) begin errors++; $display("FAIL rd_ram: got %b expected 10", {bus.ram_chipselect, bus.ram_write}); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (bus.m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_rdv0: got %b expected 1", bus.m0_readdatavalid); end
        checks++; if (bus.m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data0: got %h expected deadbeef", bus.m0_readdata); end
        checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv1: got %b expected 0", bus.m1_readdatavalid); end
        next_cycle();
    endtask

    task automatic test_alternation();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
            drive(1, 1, 0, 10'h005, 32'h0, 4'hF);
            @(negedge clk);
            checks++; if (bus.m0_waitrequest !== (k % 2 == 1)) begin errors++; $display("FAIL alt_wait0[%0d]: got %b", k, bus.m0_waitrequest); end
            checks++; if (bus.m1_waitrequest !== (k % 2 == 0)) begin errors++; $display("FAIL alt_wait1[%0d]: got %b", k, bus.m1_waitrequest); end
            checks++; if (stat_conflicts !== 16'(k)) begin errors++; $display("FAIL alt_stat[%0d]: got %0d expected %0d", k, stat_conflicts, k); end
            if (k > 0) begin
                checks++; if ({bus.m1_readdatavalid, bus.m0_readdatavalid} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_rdv[%0d]: got m1m0=%b", k, {bus.m1_readdatavalid, bus.m0_readdatavalid}); end
                checks++; if (bus.ram_readdata !== exp_mem[5]) begin errors++; $display("FAIL alt_data[%0d]: got %h expected %h", k, bus.ram_readdata, exp_mem[5]); end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_byte_enable();
        drive(1, 0, 1, 10'h3FF, 32'hAAAAAAAA, 4'hF);
        exp_write(10'h3FF, 32'hAAAAAAAA, 4'hF);
        @(negedge clk);
        checks++; if (bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL be_wait1: got %b expected 0", bus.m1_waitrequest); end
        next_cycle();
        drive(1, 0, 1, 10'h3FF, 32'h11223344, 4'b0010);
        exp_write(10'h3FF, 32'h11223344, 4'b0010);
        next_cycle();
        drive(1, 1, 0, 10'h3FF, 32'h0, 4'hF);
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (bus.m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL be_rdv1: got %b expected 1", bus.m1_readdatavalid); end
        checks++; if (bus.m1_readdata !== 32'hAAAA33AA) begin errors++; $display("FAIL be_data: got %h expected aaaa33aa", bus.m1_readdata); end
        checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL be_rdv0: got %b expected 0", bus.m0_readdatavalid); end
        next_cycle();
    endtask

    task automatic test_freeze();
        do_reset();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL frz_accept: got %b expected 0", bus.m0_waitrequest); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            freeze = 1;
            drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
            drive(1, 1, 0, 10'h3FF, 32'h0, 4'hF);
            @(negedge clk);
            checks++; if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL frz_wait[%0d]: got %b expected 11", i, {bus.m0_waitrequest, bus.m1_waitrequest}); end
            checks++; if ({bus.ram_chipselect, bus.ram_clken} !== 2'b00) begin errors++; $display("FAIL frz_cs_clken[%0d]: got %b expected 00", i, {bus.ram_chipselect, bus.ram_clken}); end
            checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL frz_stat[%0d]: got %h expected 0000", i, stat_conflicts); end
            checks++; if (bus.m0_readdatavalid !== (i == 0)) begin errors++; $display("FAIL frz_rdv0[%0d]: got %b", i, bus.m0_readdatavalid); end
            if (i == 0) begin
                checks++; if (bus.m0_readdata !== exp_mem[5]) begin errors++; $display("FAIL frz_data: got %h expected %h", bus.m0_readdata, exp_mem[5]); end
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL frz_after_rdv: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid}); end
        checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL frz_after_stat: got %h expected 0000", stat_conflicts); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        drive(1, 1, 0, 10'h005, 32'h0, 4'hF);
        next_cycle();
        idle();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if (bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rmr_accept: got %b expected 0", bus.m0_waitrequest); end
        next_cycle();
        idle();
        reset = 1;
        @(negedge clk);
        checks++; if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rmr_rdv_in: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid}); end
        checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL rmr_stat: got %h expected 0000", stat_conflicts); end
        next_cycle();
        reset = 0;
        @(negedge clk);
        checks++; if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rmr_rdv_after: got %b expected 00", {bus.m0_readdatavalid, bus.m1_readdatavalid}); end
        next_cycle();
        drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
        drive(1, 1, 0, 10'h005, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if ({bus.m0_waitrequest, bus.m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL rmr_first_conflict: got w0w1=%b expected 01", {bus.m0_waitrequest, bus.m1_waitrequest}); end
        next_cycle();
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k <= 32'hFFFE + 3; k++) begin
            drive(0, 1, 0, 10'h005, 32'h0, 4'hF);
            drive(1, 1, 0, 10'h005, 32'h0, 4'hF);
            @(negedge clk);
            if (k == 32'hFFFE) begin
                checks++; if (stat_conflicts !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected fffe", stat_conflicts); end
            end else if (k > 32'hFFFE) begin
                checks++; if (stat_conflicts !== 16'hFFFF) begin errors++; $display("FAIL sat_hold[%0d]: got %h expected ffff", k - 32'hFFFE, stat_conflicts); end
            end
            next_cycle();
        end
        stat_clear = 1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (stat_conflicts !== 16'h0) begin errors++; $display("FAIL sat_clear: got %h expected 0000", stat_conflicts); end
        next_cycle();
    endtask

    task automatic test_random();
        int          m_last;
        logic        m_pend;
        int          m_port;
        logic [31:0] m_data;
        int          m_cnt;
        do_reset();
        for (int a = 0; a < 16; a++) begin
            logic [31:0] d;
            d = $urandom;
            drive(0, 0, 1, 10'(a), d, 4'hF);
            exp_write(10'(a), d, 4'hF);
            next_cycle();
        end
        idle();
        m_last = 0; m_pend = 0; m_port = 0; m_data = '0; m_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        rd [2];
            logic        wr [2];
            logic [9:0]  ad [2];
            logic [31:0] dt [2];
            logic [3:0]  be [2];
            logic        q0, q1, fr, sc;
            int          win;
            for (int p = 0; p < 2; p++) begin
                int kind;
                kind  = $urandom_range(0, 7);
                rd[p] = (kind >= 2 && kind <= 4) || kind == 7;
                wr[p] = kind >= 5;
                ad[p] = 10'($urandom_range(0, 15));
                dt[p] = $urandom;
                be[p] = 4'($urandom_range(0, 15));
                drive(p, rd[p], wr[p], ad[p], dt[p], be[p]);
            end
            fr = ($urandom_range(0, 9) == 0);
            sc = ($urandom_range(0, 15) == 0);
            freeze = fr;
            stat_clear = sc;
            q0 = rd[0] | wr[0];
            q1 = rd[1] | wr[1];
            if (fr)            win = -1;
            else if (q0 && q1) win = (m_last == 0) ? 1 : 0;
            else if (q0)       win = 0;
            else if (q1)       win = 1;
            else               win = -1;
            @(negedge clk);
            checks++; if (bus.m0_waitrequest !== (fr | (q0 && win != 0))) begin errors++; $display("FAIL rnd_wait0[%0d]: got %b", c, bus.m0_waitrequest); end
            checks++; if (bus.m1_waitrequest !== (fr | (q1 && win != 1))) begin errors++; $display("FAIL rnd_wait1[%0d]: got %b", c, bus.m1_waitrequest); end
            checks++; if (bus.ram_chipselect !== (win >= 0)) begin errors++; $display("FAIL rnd_cs[%0d]: got %b expected %b", c, bus.ram_chipselect, win >= 0); end
            checks++; if (bus.m0_readdatavalid !== (m_pend && m_port == 0)) begin errors++; $display("FAIL rnd_rdv0[%0d]: got %b", c, bus.m0_readdatavalid); end
            checks++; if (bus.m1_readdatavalid !== (m_pend && m_port == 1)) begin errors++; $display("FAIL rnd_rdv1[%0d]: got %b", c, bus.m1_readdatavalid); end
            if (m_pend) begin
                checks++; if (bus.ram_readdata !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, bus.ram_readdata, m_data); end
            end
            checks++; if (stat_conflicts !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_stat[%0d]: got %0d expected %0d", c, stat_conflicts, m_cnt); end
            m_pend = 0;
            if (win >= 0) begin
                m_last = win;
                if (wr[win]) begin
                    exp_write(ad[win], dt[win], be[win]);
                end else begin
                    m_pend = 1;
                    m_port = win;
                    m_data = exp_mem[ad[win]];
                end
            end
            if (sc)                             m_cnt = 0;
            else if (q0 && q1 && !fr && m_cnt < 65535) m_cnt++;
            next_cycle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternation();
        test_byte_enable();
        test_freeze();
        test_reset_mid_read();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
